// File: rtl/bit_stream_realigner.sv
// ---------------------------------------------------------------------------
// bit_stream_realigner
//
// Purpose:
//   Re-packs a bitstream that starts at bit 'offset' of its first input word
//   onto output word boundaries. The previous input word is held and funnel-
//   shifted together with the current one, so each accepted input word yields
//   one output word. The last output word is zero-filled above the residual
//   bits. With offset 0 the block is a one-cycle pass-through.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-high
//   offset_in     bit offset of stream start in the first word
//   offset_load   capture offset_in (only while IDLE)
//   input_valid   / input_ready  / input_data  / input_last   - upstream side
//   output_valid  / output_ready / output_data / output_last  - downstream side
// ---------------------------------------------------------------------------
module bit_stream_realigner #(
    parameter int WORD_WIDTH   = 8,
    parameter int OFFSET_WIDTH = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [OFFSET_WIDTH-1:0] offset_in,
    input  logic                    offset_load,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic [WORD_WIDTH-1:0]   input_data,
    input  logic                    input_last,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic [WORD_WIDTH-1:0]   output_data,
    output logic                    output_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [OFFSET_WIDTH-1:0] off_q,   off_d;
    logic [WORD_WIDTH-1:0]   hold_q,  hold_d;
    logic                    ovalid_q, ovalid_d;
    logic [WORD_WIDTH-1:0]   odata_q,  odata_d;
    logic                    olast_q,  olast_d;

    logic                    free;
    logic                    accept;
    logic [OFFSET_WIDTH-1:0] off_eff;
    logic [2*WORD_WIDTH-1:0] funnel;
    logic [WORD_WIDTH-1:0]   flush_word;

    // One-deep output register: a new word may be written when it is empty
    // or being drained this cycle.
    assign free   = !ovalid_q || output_ready;
    assign accept = input_valid && input_ready;

    // A load in the same cycle as the first accepted word must already
    // steer that word, so bypass the offset register while IDLE.
    assign off_eff = (state_q == IDLE && offset_load) ? offset_in : off_q;

    // Current word on top of the held word; the low W bits after the shift
    // are the output word straddling the two.
    assign funnel     = {input_data, hold_q} >> off_eff;
    // Residual bits of the final word; zeros shift in from above.
    assign flush_word = hold_q >> off_eff;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // Offset 0 never needs a held word: stay in pass-through.
                if (accept && off_eff != '0) begin
                    state_d = input_last ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (accept && input_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (free) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath logic
    // -----------------------------------------------------------------------
    // No input is taken while the held word is being flushed.
    assign input_ready = free && (state_q != FLUSH);

    always_comb begin
        off_d    = off_q;
        hold_d   = hold_q;
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        olast_d  = olast_q;

        if (state_q == IDLE && offset_load) begin
            off_d = offset_in;
        end

        // Slot is consumed (or was empty); a new word below may refill it.
        // When not free everything holds, which gives the backpressure freeze.
        if (free) begin
            ovalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (off_eff == '0) begin
                        ovalid_d = 1'b1;
                        odata_d  = input_data;
                        olast_d  = input_last;
                    end else begin
                        hold_d = input_data;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    ovalid_d = 1'b1;
                    odata_d  = funnel[WORD_WIDTH-1:0];
                    olast_d  = 1'b0;
                    hold_d   = input_data;
                end
            end
            FLUSH: begin
                if (free) begin
                    ovalid_d = 1'b1;
                    odata_d  = flush_word;
                    olast_d  = 1'b1;
                    hold_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            off_q    <= '0;
            hold_q   <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            olast_q  <= 1'b0;
        end else begin
            off_q    <= off_d;
            hold_q   <= hold_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            olast_q  <= olast_d;
        end
    end

    assign output_valid = ovalid_q;
    assign output_data  = odata_q;
    assign output_last  = olast_q;

endmodule

// File: tb/tb_bit_stream_realigner.sv
// Testbench for bit_stream_realigner (WORD_WIDTH=8). Expected output words
// are computed from a flat bit-vector model of the stream and queued when a
// stream is offered; a monitor pops and compares on every output handshake.
module tb_bit_stream_realigner;
    localparam int W  = 8;
    localparam int OW = 3;

    logic          clock;
    logic          reset;
    logic [OW-1:0] offset_in;
    logic          offset_load;
    logic          input_valid;
    logic          input_ready;
    logic [W-1:0]  input_data;
    logic          input_last;
    logic          output_valid;
    logic          output_ready;
    logic [W-1:0]  output_data;
    logic          output_last;

    bit_stream_realigner #(.WORD_WIDTH(W), .OFFSET_WIDTH(OW)) dut (
        .clock        (clock),
        .reset        (reset),
        .offset_in    (offset_in),
        .offset_load  (offset_load),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .input_last   (input_last),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .output_last  (output_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    logic [W:0] sb[$];   // {last, data}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled away from the active edge.
    always @(negedge clock) begin
        if (!reset && output_valid && output_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(output_data), 32'hFFFF_FFFF);
            end else begin
                logic [W:0] e;
                e = sb.pop_front();
                chk("out_data", 32'(output_data), 32'(e[W-1:0]));
                chk("out_last", 32'(output_last), 32'(e[W]));
            end
        end
    end

    // Reference: lay words end to end, drop 'off' bits, re-slice.
    task automatic push_exp(input logic [W-1:0] ws[$], input int off);
        logic [71:0] s;
        int n;
        n = ws.size();
        s = '0;
        for (int i = 0; i < n; i++) s[W*i +: W] = ws[i];
        s = s >> off;
        for (int k = 0; k < n; k++) sb.push_back({(k == n - 1), s[W*k +: W]});
    endtask

    // All drivers run in the phase just after a rising edge.
    task automatic send(input logic [W-1:0] w, input logic last);
        int cyc;
        input_valid = 1'b1;
        input_data  = w;
        input_last  = last;
        cyc = 0;
        @(negedge clock);
        while (!input_ready && cyc < 100) begin
            cyc++;
            @(negedge clock);
        end
        if (!input_ready) chk("send_timeout", 32'(input_ready), 32'd1);
        @(posedge clock);
        #1;
        input_valid = 1'b0;
        input_last  = 1'b0;
    endtask

    task automatic send_stream(input logic [W-1:0] ws[$]);
        for (int i = 0; i < ws.size(); i++) send(ws[i], (i == ws.size() - 1));
    endtask

    task automatic load_off(input logic [OW-1:0] o);
        offset_in   = o;
        offset_load = 1'b1;
        @(posedge clock);
        #1;
        offset_load = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ws[$];
        int off;

        reset = 1'b1; offset_in = '0; offset_load = 1'b0;
        input_valid = 1'b0; input_data = '0; input_last = 1'b0;
        output_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", 32'(output_valid), 32'd0);
        chk("rst_data",  32'(output_data),  32'd0);
        chk("rst_last",  32'(output_last),  32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("idle_ready", 32'(input_ready), 32'd1);

        // off=4, 21 43 65 -> 32 54 06(last)
        load_off(3'd4);
        ws = '{8'h21, 8'h43, 8'h65};
        push_exp(ws, 4);
        send_stream(ws);
        wait_drain();

        // off=0 pass-through with 1-cycle latency
        load_off(3'd0);
        ws = '{8'hA5, 8'h3C};
        push_exp(ws, 0);
        send(8'hA5, 1'b0);
        @(negedge clock);
        chk("pt_lat_valid", 32'(output_valid), 32'd1);
        chk("pt_lat_data",  32'(output_data),  32'hA5);
        @(posedge clock);
        #1;
        send(8'h3C, 1'b1);
        wait_drain();

        // off=7 loaded together with a single-word stream 0x80
        ws = '{8'h80};
        push_exp(ws, 7);
        offset_in   = 3'd7;
        offset_load = 1'b1;
        send(8'h80, 1'b1);
        offset_load = 1'b0;
        wait_drain();

        // backpressure mid-stream for 5 cycles
        load_off(3'd4);
        ws = '{8'h21, 8'h43, 8'h65};
        push_exp(ws, 4);
        send(8'h21, 1'b0);
        send(8'h43, 1'b0);
        output_ready = 1'b0;
        input_valid  = 1'b1;
        input_data   = 8'h65;
        input_last   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_in_ready", 32'(input_ready),  32'd0);
            chk("bp_valid",    32'(output_valid), 32'd1);
            chk("bp_data",     32'(output_data),  32'h32);
        end
        @(posedge clock);
        #1;
        output_ready = 1'b1;
        send(8'h65, 1'b1);
        wait_drain();

        // offset load while RUN is ignored
        load_off(3'd4);
        ws = '{8'h21, 8'h43, 8'h65};
        push_exp(ws, 4);
        send(8'h21, 1'b0);
        offset_in   = 3'd2;
        offset_load = 1'b1;
        send(8'h43, 1'b0);
        send(8'h65, 1'b1);
        offset_load = 1'b0;
        wait_drain();

        // reset in RUN with an output pending
        load_off(3'd4);
        send(8'h21, 1'b0);
        output_ready = 1'b0;
        send(8'h43, 1'b0);
        @(negedge clock);
        chk("pre_rst_valid", 32'(output_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(output_valid), 32'd0);
        chk("mid_rst_data",  32'(output_data),  32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        output_ready = 1'b1;
        chk("post_rst_ready", 32'(input_ready), 32'd1);
        load_off(3'd1);
        ws = '{8'h03, 8'h00};
        push_exp(ws, 1);
        send_stream(ws);
        wait_drain();

        // a few random streams
        for (int t = 0; t < 6; t++) begin
            int n;
            n   = $urandom_range(1, 6);
            off = $urandom_range(0, 7);
            ws.delete();
            for (int i = 0; i < n; i++) ws.push_back(8'($urandom));
            load_off(3'(off));
            push_exp(ws, off);
            send_stream(ws);
            wait_drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
